// File: rtl/mem_stage_pkg.sv
// Shared pipeline types for the memory-access stage: control/bus structs,
// the MEM FSM state enum and the MemSize to bus-size mapping.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } MemSizeType;

  typedef enum logic [2:0] {
    WBNoHandle = 3'd0,
    WB_7       = 3'd1,
    WB_7_sext  = 3'd2,
    WB_15      = 3'd3,
    WB_15_sext = 3'd4,
    WB_31      = 3'd5,
    WB_31_sext = 3'd6,
    WB_63      = 3'd7
  } WBType;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    MemSizeType MemSize;
    WBType      wbType;
  } control_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw_instr;
    control_t    ctl;
    logic [4:0]  dst;
    logic [63:0] alu_out;
    logic [63:0] rd2;
    logic [11:0] csr;
    logic [63:0] csr_rdata;
  } execute_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw_instr;
    control_t    ctl;
    logic [4:0]  dst;
    logic [63:0] alu_out;
    logic [63:0] MemReadData;
    logic        skip;
    logic [11:0] csr;
    logic [63:0] csr_rdata;
  } memory_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  function automatic msize_t to_msize(input MemSizeType s);
    msize_t m;
    case (s)
      MEM_B:   m = MSIZE1;
      MEM_H:   m = MSIZE2;
      MEM_W:   m = MSIZE4;
      MEM_D:   m = MSIZE8;
      default: m = MSIZE8;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment for the data bus: store strobe/data placement and
// load shift plus zero/sign extension. Purely combinational.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  st_off,
  input  msize_t      st_size,
  input  logic        st_write,
  input  logic [63:0] rd2,
  output logic [7:0]  strobe,
  output logic [63:0] wdata,
  input  logic [2:0]  ld_off,
  input  WBType       wb_type,
  input  logic [63:0] rdata,
  output logic [63:0] rdata_fmt
);

  logic [63:0] shifted_s;

  // Store side: lane strobe from size/offset, data moved up to its byte lane
  always_comb begin
    strobe = 8'h00;
    if (st_write) begin
      case (st_size)
        MSIZE1:  strobe = 8'h01 << st_off;
        MSIZE2:  strobe = 8'h03 << st_off;
        MSIZE4:  strobe = 8'h0F << st_off;
        MSIZE8:  strobe = 8'hFF;
        default: strobe = 8'hFF;
      endcase
    end else begin
      strobe = 8'h00;
    end
    wdata = rd2 << {st_off, 3'b000};
  end

  assign shifted_s = rdata >> {ld_off, 3'b000};

  // Load side: bring the addressed bytes to bit 0, then extend to 64 bits
  always_comb begin
    rdata_fmt = shifted_s;
    case (wb_type)
      WB_7:       rdata_fmt = {56'd0, shifted_s[7:0]};
      WB_7_sext:  rdata_fmt = {{56{shifted_s[7]}}, shifted_s[7:0]};
      WB_15:      rdata_fmt = {48'd0, shifted_s[15:0]};
      WB_15_sext: rdata_fmt = {{48{shifted_s[15]}}, shifted_s[15:0]};
      WB_31:      rdata_fmt = {32'd0, shifted_s[31:0]};
      WB_31_sext: rdata_fmt = {{32{shifted_s[31]}}, shifted_s[31:0]};
      WB_63:      rdata_fmt = shifted_s;
      WBNoHandle: rdata_fmt = shifted_s;
      default:    rdata_fmt = shifted_s;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV64 memory-access stage: one data-bus transaction per memory op, upstream
// stall while it is outstanding, and the MEM/WB pipeline register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MMIO_BIT = 31
) (
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output memory_data_t  dataM,
  output logic          stall_mem
);

  mem_state_t   state_r;
  mem_state_t   state_s;
  dbus_req_t    req_r;
  WBType        wb_r;
  logic         load_r;
  memory_data_t mem_r;

  logic         mem_op_s;
  logic         issue_s;
  logic         done_s;
  logic         pass_s;
  msize_t       size_s;
  logic [7:0]   strobe_s;
  logic [63:0]  wdata_s;
  logic [63:0]  rdata_fmt_s;
  logic         unused_addr_ok;

  assign unused_addr_ok = dresp.addr_ok;
  assign mem_op_s       = dataE.valid & (dataE.ctl.MemRead | dataE.ctl.MemWrite);
  assign size_s         = to_msize(dataE.ctl.MemSize);

  mem_align u_align (
    .st_off    (dataE.alu_out[2:0]),
    .st_size   (size_s),
    .st_write  (dataE.ctl.MemWrite),
    .rd2       (dataE.rd2),
    .strobe    (strobe_s),
    .wdata     (wdata_s),
    .ld_off    (req_r.addr[2:0]),
    .wb_type   (wb_r),
    .rdata     (dresp.data),
    .rdata_fmt (rdata_fmt_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = mem_op_s ? REQ : IDLE;
      REQ:     state_s = dresp.data_ok ? IDLE : REQ;
      default: state_s = IDLE;
    endcase
  end

  // FSM outputs; stall is forced low while reset is held so nothing upstream freezes
  always_comb begin
    issue_s = 1'b0;
    done_s  = 1'b0;
    pass_s  = 1'b0;
    case (state_r)
      IDLE: begin
        issue_s = mem_op_s;
        pass_s  = dataE.valid & ~mem_op_s;
      end
      REQ: begin
        done_s = dresp.data_ok;
      end
      default: begin
        issue_s = 1'b0;
      end
    endcase
    stall_mem = reset & (issue_s | ((state_r == REQ) & ~dresp.data_ok));
  end

  // Request registers: loaded on issue, held through REQ, cleared on data_ok
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_r  <= '0;
      wb_r   <= WBNoHandle;
      load_r <= 1'b0;
    end else if (issue_s) begin
      req_r.valid  <= 1'b1;
      req_r.addr   <= dataE.alu_out;
      req_r.size   <= size_s;
      req_r.strobe <= strobe_s;
      req_r.data   <= wdata_s;
      wb_r         <= dataE.ctl.wbType;
      load_r       <= dataE.ctl.MemRead;
    end else if (done_s) begin
      req_r <= '0;
    end else begin
      req_r <= req_r;
    end
  end

  assign dreq = req_r;

  // MEM/WB register: one valid pulse per instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_r <= '0;
    end else begin
      mem_r.valid <= pass_s | done_s;
      if (pass_s | done_s) begin
        mem_r.pc          <= dataE.pc;
        mem_r.raw_instr   <= dataE.raw_instr;
        mem_r.ctl         <= dataE.ctl;
        mem_r.dst         <= dataE.dst;
        mem_r.alu_out     <= dataE.alu_out;
        mem_r.csr         <= dataE.csr;
        mem_r.csr_rdata   <= dataE.csr_rdata;
        mem_r.MemReadData <= (done_s & load_r) ? rdata_fmt_s : 64'd0;
        mem_r.skip        <= done_s & ~req_r.addr[MMIO_BIT];
      end else begin
        mem_r.MemReadData <= mem_r.MemReadData;
      end
    end
  end

  assign dataM = mem_r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a byte-level reference model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  execute_data_t dataE;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;
  memory_data_t  dataM;
  logic          stall_mem;

  always #5 clk = ~clk;

  mem_stage #(.MMIO_BIT(31)) dut (
    .clk(clk), .reset(reset), .dataE(dataE), .dreq(dreq),
    .dresp(dresp), .dataM(dataM), .stall_mem(stall_mem)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] alu_out;
    logic [4:0]  dst;
    logic [63:0] rd;
    logic        skip;
  } exp_t;

  exp_t        exp_q[$];
  int          due_cnt = 0;
  int          seen_cnt = 0;
  logic [63:0] last_rd = 64'd0;
  logic        last_skip = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: byte arithmetic straight from the bus rules
  function automatic logic [7:0] m_strobe(input int bytes, input logic [63:0] addr);
    int o = int'(addr[2:0]);
    logic [15:0] m;
    m = ((16'd1 << bytes) - 16'd1) << o;
    return m[7:0];
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] rd2, input logic [63:0] addr);
    int o = int'(addr[2:0]);
    return rd2 << (8 * o);
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rdata, input logic [63:0] addr,
                                         input int bytes, input logic sext);
    int o = int'(addr[2:0]);
    logic [63:0] s, mask, v;
    s = rdata >> (8 * o);
    mask = (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * bytes)) - 64'd1);
    v = s & mask;
    if (sext && bytes < 8 && v[8 * bytes - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic execute_data_t mk_e(input logic ld, input logic st, input int bytes,
                                         input logic sext, input logic [63:0] addr,
                                         input logic [63:0] rd2, input logic [63:0] pc);
    execute_data_t e;
    e = '0;
    e.valid = 1'b1;
    e.pc = pc;
    e.raw_instr = 32'h0000_0013;
    e.dst = 5'd10;
    e.alu_out = addr;
    e.rd2 = rd2;
    e.ctl.RegWrite = ~st;
    e.ctl.MemRead = ld;
    e.ctl.MemWrite = st;
    case (bytes)
      1: e.ctl.MemSize = MEM_B;
      2: e.ctl.MemSize = MEM_H;
      4: e.ctl.MemSize = MEM_W;
      default: e.ctl.MemSize = MEM_D;
    endcase
    if (ld) begin
      case (bytes)
        1: e.ctl.wbType = sext ? WB_7_sext : WB_7;
        2: e.ctl.wbType = sext ? WB_15_sext : WB_15;
        4: e.ctl.wbType = sext ? WB_31_sext : WB_31;
        default: e.ctl.wbType = WB_63;
      endcase
    end else begin
      e.ctl.wbType = WBNoHandle;
    end
    return e;
  endfunction

  // Present one instruction at the current cycle and respond data_ok k cycles later
  task automatic do_op(input string name, input logic ld, input logic st, input int bytes,
                       input logic sext, input logic [63:0] addr, input logic [63:0] rd2,
                       input logic [63:0] rdata, input int k, input logic [63:0] pc);
    logic mem = ld | st;
    exp_t e;
    int last = mem ? k : 0;
    dataE = mk_e(ld, st, bytes, sext, addr, rd2, pc);
    for (int c = 0; c <= last; c++) begin
      dresp.addr_ok = 1'b0;
      dresp.data_ok = mem && (c == last);
      dresp.data = (c == last) ? rdata : 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      chk({name, ".stall"}, 64'(stall_mem), 64'(mem && (c < last)));
      chk({name, ".dreq_valid"}, 64'(dreq.valid), 64'(mem && (c >= 1)));
      if (mem && c >= 1) begin
        chk({name, ".addr"}, dreq.addr, addr);
        chk({name, ".size"}, 64'(dreq.size), 64'($clog2(bytes)));
        chk({name, ".strobe"}, 64'(dreq.strobe), st ? 64'(m_strobe(bytes, addr)) : 64'd0);
        if (st) chk({name, ".wdata"}, dreq.data, m_wdata(rd2, addr));
      end
      @(posedge clk);
      if (c == last) begin
        e.pc = pc;
        e.alu_out = addr;
        e.dst = 5'd10;
        e.rd = ld ? m_load(rdata, addr, bytes, sext) : 64'd0;
        e.skip = mem ? ~addr[31] : 1'b0;
        exp_q.push_back(e);
        due_cnt++;
      end
      #1;
    end
  endtask

  task automatic idle(input int n, input logic ok);
    for (int i = 0; i < n; i++) begin
      dataE = mk_e(1'b1, 1'b0, 8, 1'b0, 64'h8000_0000, 64'd0, 64'd0);
      dataE.valid = 1'b0;
      dresp.data_ok = ok;
      dresp.data = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      chk("idle.stall", 64'(stall_mem), 64'd0);
      chk("idle.dreq_valid", 64'(dreq.valid), 64'd0);
      @(posedge clk);
      #1;
    end
  endtask

  // Compare process: dataM pulses exactly when due, with model contents
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (seen_cnt < due_cnt) begin
        chk("dataM.valid", 64'(dataM.valid), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("dataM.pc", dataM.pc, e.pc);
          chk("dataM.alu_out", dataM.alu_out, e.alu_out);
          chk("dataM.dst", 64'(dataM.dst), 64'(e.dst));
          chk("dataM.rdata", dataM.MemReadData, e.rd);
          chk("dataM.skip", 64'(dataM.skip), 64'(e.skip));
          last_rd = dataM.MemReadData;
          last_skip = dataM.skip;
        end
        seen_cnt++;
      end else begin
        chk("dataM.valid_idle", 64'(dataM.valid), 64'd0);
      end
    end
  end

  initial begin
    dresp = '0;
    dataE = mk_e(1'b1, 1'b0, 8, 1'b0, 64'h8000_0000, 64'd0, 64'd0);
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset state, with a memory op presented to show stall stays low
    chk("rst.dreq_valid", 64'(dreq.valid), 64'd0);
    chk("rst.dreq_addr", dreq.addr, 64'd0);
    chk("rst.dreq_strobe", 64'(dreq.strobe), 64'd0);
    chk("rst.dreq_data", dreq.data, 64'd0);
    chk("rst.dataM_valid", 64'(dataM.valid), 64'd0);
    chk("rst.dataM_pc", dataM.pc, 64'd0);
    chk("rst.stall", 64'(stall_mem), 64'd0);
    dataE.valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // model pins
    chk("model.lb", m_load(64'h0000_0000_80FF_0000, 64'h8000_0003, 1, 1'b1), 64'hFFFF_FFFF_FFFF_FF80);
    chk("model.sh_strobe", 64'(m_strobe(2, 64'h8000_0006)), 64'h0000_0000_0000_00C0);
    chk("model.sh_data", m_wdata(64'hABCD, 64'h8000_0006), 64'hABCD_0000_0000_0000);
    chk("model.lwu", m_load(64'h1234_5678_8000_0001, 64'h4000_0000, 4, 1'b0), 64'h0000_0000_8000_0001);

    do_op("add", 1'b0, 1'b0, 8, 1'b0, 64'h1234, 64'd0, 64'd0, 0, 64'h100);
    idle(1, 1'b0);
    chk("add.rdata_lit", last_rd, 64'd0);

    do_op("lb", 1'b1, 1'b0, 1, 1'b1, 64'h8000_0003, 64'd0, 64'h0000_0000_80FF_0000, 3, 64'h104);
    idle(1, 1'b1);
    chk("lb.rdata_lit", last_rd, 64'hFFFF_FFFF_FFFF_FF80);

    do_op("sh", 1'b0, 1'b1, 2, 1'b0, 64'h8000_0006, 64'hABCD, 64'd0, 2, 64'h108);
    idle(1, 1'b0);
    chk("sh.skip_lit", 64'(last_skip), 64'd0);

    do_op("lw", 1'b1, 1'b0, 4, 1'b1, 64'h4000_0000, 64'd0, 64'h1234_5678_8000_0001, 1, 64'h10C);
    idle(1, 1'b0);
    chk("lw.rdata_lit", last_rd, 64'hFFFF_FFFF_8000_0001);
    chk("lw.skip_lit", 64'(last_skip), 64'd1);
    do_op("lwu", 1'b1, 1'b0, 4, 1'b0, 64'h4000_0000, 64'd0, 64'h1234_5678_8000_0001, 1, 64'h110);
    idle(1, 1'b0);
    chk("lwu.rdata_lit", last_rd, 64'h0000_0000_8000_0001);

    do_op("lh", 1'b1, 1'b0, 2, 1'b1, 64'h8000_0002, 64'd0, 64'h0000_0000_F00D_0000, 2, 64'h114);
    do_op("lhu", 1'b1, 1'b0, 2, 1'b0, 64'h8000_0002, 64'd0, 64'h0000_0000_F00D_0000, 1, 64'h118);
    do_op("sb", 1'b0, 1'b1, 1, 1'b0, 64'h8000_0005, 64'h5A, 64'd0, 1, 64'h11C);
    do_op("sw", 1'b0, 1'b1, 4, 1'b0, 64'h8000_0004, 64'hCAFE_F00D, 64'd0, 2, 64'h120);
    do_op("ld", 1'b1, 1'b0, 8, 1'b0, 64'h8000_0010, 64'd0, 64'h0123_4567_89AB_CDEF, 2, 64'h124);
    do_op("sd", 1'b0, 1'b1, 8, 1'b0, 64'h8000_0018, 64'h1122_3344_5566_7788, 64'd0, 1, 64'h128);
    do_op("addi", 1'b0, 1'b0, 8, 1'b0, 64'h8000_0000, 64'd0, 64'd0, 0, 64'h12C);
    idle(2, 1'b0);

    // reset while a load is outstanding
    dataE = mk_e(1'b1, 1'b0, 8, 1'b0, 64'h8000_0020, 64'd0, 64'h130);
    dresp = '0;
    @(posedge clk);
    #1;
    chk("rstreq.dreq_valid_before", 64'(dreq.valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("rstreq.dreq_valid", 64'(dreq.valid), 64'd0);
    chk("rstreq.dataM_valid", 64'(dataM.valid), 64'd0);
    chk("rstreq.stall", 64'(stall_mem), 64'd0);
    dataE.valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_op("ld2", 1'b1, 1'b0, 8, 1'b0, 64'h8000_0028, 64'd0, 64'hFEDC_BA98_7654_3210, 2, 64'h134);
    idle(2, 1'b0);
    chk("ld2.rdata_lit", last_rd, 64'hFEDC_BA98_7654_3210);

    chk("drain.pulses", 64'(seen_cnt), 64'(due_cnt));
    chk("drain.queue", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
